// File: rtl/lfsr_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_ctrl_pkg
// Description : Shared definitions for the LFSR sequencing controller.
//               Contents:
//               - state encoding
//               - default seed
//               - state_o width
//               - seed-sanitising helper
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_ctrl_pkg;

    // Width of the externally visible state code.
    localparam int STATE_W = 2;

    // Seed loaded out of reset, and used in place of any all-zero seed.
    localparam logic [7:0] DEFAULT_SEED = 8'h01;

    // Controller states. The numeric codes are visible on state_o.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LOAD  = 2'd3
    } state_e;

    // An all-zero seed would lock an XOR LFSR at zero forever, so it is
    // swapped for the supplied default.
    function automatic logic [7:0] sanitize_seed(input logic [7:0] seed,
                                                 input logic [7:0] dflt);
        return (seed == 8'h00) ? dflt : seed;
    endfunction

endpackage : lfsr_ctrl_pkg
`default_nettype wire

// File: rtl/lfsr_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl_if
// Description : Command, seed-load and LFSR-control bundle of the LFSR
//               sequencing controller.
//   cmd_run    : run (1) / pause (0) level
//   cmd_step   : single-step request, edge detected by the controller
//   rate_sel   : prescaler rate select
//   seed_valid : seed offer
//   seed_data  : seed offer data
//   seed_ready : controller can accept a seed
//   lfsr_q     : current LFSR state fed back from the datapath
//   lfsr_en    : one-cycle advance strobe
//   lfsr_load  : one-cycle parallel-load strobe
//   lfsr_seed  : value to load while lfsr_load is high
//   state_o    : controller state code
//   tick_o     : prescaler terminal-count pulse
// Modports    : slave  - the controller
//               master - the surrounding system / datapath
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_seq_ctrl_if;
    import lfsr_ctrl_pkg::*;

    logic               cmd_run;
    logic               cmd_step;
    logic [2:0]         rate_sel;
    logic               seed_valid;
    logic [7:0]         seed_data;
    logic               seed_ready;
    logic [7:0]         lfsr_q;
    logic               lfsr_en;
    logic               lfsr_load;
    logic [7:0]         lfsr_seed;
    logic [STATE_W-1:0] state_o;
    logic               tick_o;

    modport slave (
        input  cmd_run, cmd_step, rate_sel, seed_valid, seed_data, lfsr_q,
        output seed_ready, lfsr_en, lfsr_load, lfsr_seed, state_o, tick_o
    );

    modport master (
        output cmd_run, cmd_step, rate_sel, seed_valid, seed_data, lfsr_q,
        input  seed_ready, lfsr_en, lfsr_load, lfsr_seed, state_o, tick_o
    );

endinterface : lfsr_seq_ctrl_if
`default_nettype wire

// File: rtl/lfsr_seq_ctrl_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider that produces the LFSR advance tick.
//               Period = max(1, BASE_DIV >> rate_sel_i) clk cycles.
//   clk        : system clock
//   reset      : asynchronous active-high reset, clears the counter
//   clear_i    : synchronous counter clear (priority over counting)
//   en_i       : count enable; the counter holds its value when low
//   rate_sel_i : rate select
//   tick_o     : terminal count reached this cycle (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int DIV_W    = 27,
    parameter int BASE_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [2:0] rate_sel_i,
    output logic       tick_o
);

    localparam logic [DIV_W-1:0] BASE_C = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0] ONE_C  = DIV_W'(1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;
    logic [DIV_W-1:0] shifted;
    logic [DIV_W-1:0] term;

    always_comb begin
        shifted = BASE_C >> rate_sel_i;
        // A shift result of 0 or 1 both mean a period of one cycle.
        term    = (shifted > ONE_C) ? (shifted - ONE_C) : '0;

        // >= rather than == : if the period shrinks while the count is
        // already past the new terminal value, fire on the next enabled
        // cycle instead of wrapping around the whole counter range.
        tick_o  = en_i && (count_q >= term);

        count_d = count_q;
        if (clear_i || tick_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + ONE_C;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl
// Description : Decides when the downstream 8-bit LFSR advances or loads.
//               Provides a prescaled advance strobe, run/pause, single-step
//               and a valid/ready seed-load port. All strobes are registered.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   bus        : lfsr_seq_ctrl_if.slave (commands, seed port, LFSR control)
// Parameters  : DIV_W        - prescaler counter width
//               BASE_DIV     - clk cycles per advance at rate_sel = 0
//               DEFAULT_SEED - seed after reset and substitute for zero seed
// Build macro : LFSR_LOCKUP_RECOVERY_EN - when defined, an all-zero lfsr_q
//               in RUN/PAUSE forces a reload of DEFAULT_SEED.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl #(
    parameter int         DIV_W        = 27,
    parameter int         BASE_DIV     = 100000000,
    parameter logic [7:0] DEFAULT_SEED = lfsr_ctrl_pkg::DEFAULT_SEED
) (
    input  logic           clk,
    input  logic           reset,
    lfsr_seq_ctrl_if.slave bus
);
    import lfsr_ctrl_pkg::*;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e     state_q;
    state_e     state_d;
    logic       step_prev_q;
    logic       lfsr_en_q;
    logic       lfsr_en_d;
    logic       lfsr_load_q;
    logic       lfsr_load_d;
    logic [7:0] lfsr_seed_q;
    logic [7:0] lfsr_seed_d;
    logic       tick_q;
    logic       tick_d;

    // ------------------------------------------------------------------
    // Decoded conditions
    // ------------------------------------------------------------------
    logic active;       // RUN or PAUSE
    logic step_edge;    // rising edge of cmd_step
    logic seed_ready;
    logic xfer;         // seed handshake completes this cycle
    logic lockup;       // LFSR stuck at zero, forced reload
    logic presc_en;
    logic presc_clear;
    logic presc_tick;

    assign active    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign step_edge = bus.cmd_step && !step_prev_q;

`ifdef LFSR_LOCKUP_RECOVERY_EN
    // The cycle straight after a load still shows the pre-load LFSR value,
    // so it must not be judged for lockup.
    logic first_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= 1'b1;
        end else begin
            first_q <= (state_q == ST_IDLE) || (state_q == ST_LOAD);
        end
    end

    assign lockup = active && !first_q && (bus.lfsr_q == 8'h00);
`else
    // Feedback is not used in this build; keep the port but sink it.
    logic unused_lfsr_q;
    assign unused_lfsr_q = ^bus.lfsr_q;
    assign lockup        = 1'b0;
`endif

    assign seed_ready = active && !lockup;
    assign xfer       = bus.seed_valid && seed_ready;

    // Count only while running and still asked to run: the cycle that sees
    // cmd_run fall holds the count so that a resume continues from it.
    assign presc_en    = (state_q == ST_RUN) && bus.cmd_run;
    // Any load (reset exit, handshake, lockup) restarts the advance period.
    assign presc_clear = xfer || lockup || !active;

    tick_prescaler #(
        .DIV_W    (DIV_W),
        .BASE_DIV (BASE_DIV)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (presc_clear),
        .en_i       (presc_en),
        .rate_sel_i (bus.rate_sel),
        .tick_o     (presc_tick)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lfsr_en_d   = 1'b0;
        lfsr_load_d = 1'b0;
        tick_d      = 1'b0;
        lfsr_seed_d = lfsr_seed_q;

        case (state_q)
            ST_IDLE: begin
                // Leaving reset always loads the default seed.
                lfsr_load_d = 1'b1;
                lfsr_seed_d = DEFAULT_SEED;
                state_d     = bus.cmd_run ? ST_RUN : ST_PAUSE;
            end

            ST_LOAD: begin
                state_d = bus.cmd_run ? ST_RUN : ST_PAUSE;
            end

            ST_RUN, ST_PAUSE: begin
                // Loads take precedence over advancing, which keeps
                // lfsr_en and lfsr_load mutually exclusive.
                if (lockup) begin
                    lfsr_load_d = 1'b1;
                    lfsr_seed_d = DEFAULT_SEED;
                    state_d     = ST_LOAD;
                end else if (xfer) begin
                    lfsr_load_d = 1'b1;
                    lfsr_seed_d = sanitize_seed(bus.seed_data, DEFAULT_SEED);
                    state_d     = ST_LOAD;
                end else if (state_q == ST_RUN) begin
                    if (presc_tick) begin
                        lfsr_en_d = 1'b1;
                        tick_d    = 1'b1;
                    end
                    if (!bus.cmd_run) begin
                        state_d = ST_PAUSE;
                    end
                end else begin
                    // A step edge coinciding with the resume is still taken.
                    if (step_edge) begin
                        lfsr_en_d = 1'b1;
                    end
                    if (bus.cmd_run) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_prev_q <= 1'b0;
            lfsr_en_q   <= 1'b0;
            lfsr_load_q <= 1'b0;
            lfsr_seed_q <= DEFAULT_SEED;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_prev_q <= bus.cmd_step;
            lfsr_en_q   <= lfsr_en_d;
            lfsr_load_q <= lfsr_load_d;
            lfsr_seed_q <= lfsr_seed_d;
            tick_q      <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.seed_ready = seed_ready;
    assign bus.lfsr_en    = lfsr_en_q;
    assign bus.lfsr_load  = lfsr_load_q;
    assign bus.lfsr_seed  = lfsr_seed_q;
    assign bus.state_o    = state_q;
    assign bus.tick_o     = tick_q;

endmodule : lfsr_seq_ctrl
`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_seq_ctrl
// Description : Self-checking bench for lfsr_seq_ctrl with BASE_DIV = 8.
//               Expected load seeds are queued when the cause is driven and
//               compared whenever the DUT raises lfsr_load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lfsr_seq_ctrl_if bus ();

    lfsr_seq_ctrl #(
        .DIV_W        (27),
        .BASE_DIV     (8),
        .DEFAULT_SEED (8'h01)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         en_count = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [2:0] rate;
        int         period;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and run per-cycle checks.
    task automatic cyc();
        logic [7:0] exp_seed;
        @(posedge clk);
        #1;
        if (!rst) begin
            if (bus.lfsr_en) en_count++;
            chk("en_load_exclusive", {31'd0, bus.lfsr_en & bus.lfsr_load}, 32'd0);
            chk("tick_implies_en", {31'd0, bus.tick_o & ~bus.lfsr_en}, 32'd0);
            if (bus.lfsr_load) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_load", {31'd0, bus.lfsr_load}, 32'd0);
                end else begin
                    exp_seed = sb_q.pop_front();
                    chk("sb_load_seed", {24'd0, bus.lfsr_seed}, {24'd0, exp_seed});
                end
            end
        end
    endtask

    // Advance until lfsr_en is seen; n returns the number of clocks taken.
    task automatic wait_en(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.lfsr_en && n < limit);
        if (!bus.lfsr_en) chk("wait_en_timeout", {31'd0, bus.lfsr_en}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         base;
        logic [3:0] pat;

        vecs[0] = '{rate: 3'd0, period: 8};
        vecs[1] = '{rate: 3'd1, period: 4};
        vecs[2] = '{rate: 3'd2, period: 2};
        vecs[3] = '{rate: 3'd3, period: 1};
        vecs[4] = '{rate: 3'd4, period: 1};
        vecs[5] = '{rate: 3'd7, period: 1};

        bus.cmd_run    = 1'b1;
        bus.cmd_step   = 1'b0;
        bus.rate_sel   = 3'd0;
        bus.seed_valid = 1'b0;
        bus.seed_data  = 8'h00;
        bus.lfsr_q     = 8'h5A;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {30'd0, bus.state_o}, 32'd0);
        chk("rst_en", {31'd0, bus.lfsr_en}, 32'd0);
        chk("rst_load", {31'd0, bus.lfsr_load}, 32'd0);
        chk("rst_tick", {31'd0, bus.tick_o}, 32'd0);
        chk("rst_ready", {31'd0, bus.seed_ready}, 32'd0);
        chk("rst_seed", {24'd0, bus.lfsr_seed}, 32'h01);

        // ---------------- reset release: default load, then RUN ----------------
        rst = 1'b0;
        sb_q.push_back(8'h01);
        cyc();
        chk("release_load", {31'd0, bus.lfsr_load}, 32'd1);
        chk("release_state", {30'd0, bus.state_o}, 32'd1);
        wait_en(20, n);
        chk("first_tick_latency", n, 32'd8);
        chk("first_tick_coincident", {31'd0, bus.tick_o}, 32'd1);

        // ---------------- advance period per rate_sel ----------------
        for (int i = 0; i < 6; i++) begin
            bus.rate_sel = vecs[i].rate;
            wait_en(20, n);
            wait_en(20, n);
            chk($sformatf("period_rate%0d", vecs[i].rate), n, vecs[i].period);
            chk($sformatf("tick_rate%0d", vecs[i].rate), {31'd0, bus.tick_o}, 32'd1);
        end

        // ---------------- pause at count 5, steps, resume ----------------
        bus.rate_sel = 3'd0;
        wait_en(20, n);
        repeat (5) cyc();
        bus.cmd_run = 1'b0;
        cyc();
        chk("pause_state", {30'd0, bus.state_o}, 32'd2);
        base = en_count;
        bus.cmd_step = 1'b1; cyc();
        bus.cmd_step = 1'b0; cyc();
        bus.cmd_step = 1'b1; cyc();
        bus.cmd_step = 1'b0; cyc();
        bus.cmd_step = 1'b1;
        repeat (10) cyc();
        bus.cmd_step = 1'b0; cyc();
        chk("step_pulses", en_count - base, 32'd3);
        bus.cmd_run = 1'b1;
        pat = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            cyc();
            pat = {pat[2:0], bus.lfsr_en};
        end
        chk("resume_tick_pattern", {28'd0, pat}, 32'b0001);

        // ---------------- handshake on terminal-count cycle ----------------
        repeat (7) cyc();
        bus.seed_valid = 1'b1;
        bus.seed_data  = 8'hA5;
        sb_q.push_back(8'hA5);
        cyc();
        bus.seed_valid = 1'b0;
        chk("hs_no_en", {31'd0, bus.lfsr_en}, 32'd0);
        chk("hs_no_tick", {31'd0, bus.tick_o}, 32'd0);
        chk("hs_state_load", {30'd0, bus.state_o}, 32'd3);
        chk("hs_load", {31'd0, bus.lfsr_load}, 32'd1);
        chk("hs_seed", {24'd0, bus.lfsr_seed}, 32'hA5);
        chk("hs_ready_in_load", {31'd0, bus.seed_ready}, 32'd0);
        wait_en(20, n);
        chk("tick_after_load", n, 32'd9);

        // ---------------- zero seed substitution ----------------
        bus.seed_valid = 1'b1;
        bus.seed_data  = 8'h00;
        sb_q.push_back(8'h01);
        cyc();
        bus.seed_valid = 1'b0;
        chk("zero_seed_state", {30'd0, bus.state_o}, 32'd3);
        chk("zero_seed_value", {24'd0, bus.lfsr_seed}, 32'h01);
        cyc();

        // ---------------- lfsr_q lockup in PAUSE ----------------
        bus.cmd_run = 1'b0;
        cyc();
        cyc();
        bus.lfsr_q = 8'h00;
        #1;
`ifdef LFSR_LOCKUP_RECOVERY_EN
        chk("lockup_ready", {31'd0, bus.seed_ready}, 32'd0);
        sb_q.push_back(8'h01);
        cyc();
        chk("lockup_state", {30'd0, bus.state_o}, 32'd3);
        chk("lockup_load", {31'd0, bus.lfsr_load}, 32'd1);
`else
        chk("lockup_ready", {31'd0, bus.seed_ready}, 32'd1);
        cyc();
        chk("lockup_state", {30'd0, bus.state_o}, 32'd2);
        chk("lockup_load", {31'd0, bus.lfsr_load}, 32'd0);
`endif
        bus.lfsr_q  = 8'h5A;
        bus.cmd_run = 1'b1;
        cyc();
        cyc();

        // ---------------- reset asserted during LOAD ----------------
        bus.seed_valid = 1'b1;
        bus.seed_data  = 8'h3C;
        sb_q.push_back(8'h3C);
        cyc();
        bus.seed_valid = 1'b0;
        chk("pre_reset_load_state", {30'd0, bus.state_o}, 32'd3);
        rst = 1'b1;
        #1;
        chk("rst_load_state", {30'd0, bus.state_o}, 32'd0);
        chk("rst_load_load", {31'd0, bus.lfsr_load}, 32'd0);
        chk("rst_load_en", {31'd0, bus.lfsr_en}, 32'd0);
        chk("rst_load_ready", {31'd0, bus.seed_ready}, 32'd0);
        chk("rst_load_seed", {24'd0, bus.lfsr_seed}, 32'h01);
        cyc();
        rst = 1'b0;
        sb_q.push_back(8'h01);
        cyc();
        chk("rerelease_load", {31'd0, bus.lfsr_load}, 32'd1);
        chk("rerelease_state", {30'd0, bus.state_o}, 32'd1);

        // ---------------- reset asserted mid-count ----------------
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        chk("rst_mid_state", {30'd0, bus.state_o}, 32'd0);
        chk("rst_mid_en", {31'd0, bus.lfsr_en}, 32'd0);
        chk("rst_mid_tick", {31'd0, bus.tick_o}, 32'd0);
        cyc();
        rst = 1'b0;
        sb_q.push_back(8'h01);
        cyc();
        chk("rerelease2_load", {31'd0, bus.lfsr_load}, 32'd1);
        wait_en(20, n);
        chk("rerelease2_tick_latency", n, 32'd8);

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lfsr_seq_ctrl
`default_nettype wire
